// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding and default sizes for the counter blocks
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_PRESCALE = 1;
  localparam int DEF_PS_W     = 8;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides enabled clk cycles into one tick every PRESCALE cycles
module tick_prescaler #(
  parameter int PRESCALE = 1,
  parameter int PS_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PS_W-1:0] LP_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] r_ps;

  assign tick = en && !clr && (r_ps == LP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ps <= '0;
    end else if (clr) begin
      r_ps <= '0;
    end else if (en) begin
      r_ps <= (r_ps == LP_LAST) ? '0 : r_ps + 1'b1;
    end
  end

endmodule

// File: rtl/sync_downcount_timer.sv
// rtl/sync_downcount_timer.sv - loadable prescaled down-counter with one-shot and auto-reload modes
module sync_downcount_timer
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int PS_W     = DEF_PS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             abort,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_reload, w_reload_nxt;
  logic [WIDTH-1:0] w_period;
  logic             r_tc, w_tc_nxt;
  logic             w_tick, w_ps_clr, w_ps_en;

  assign w_ps_en = (r_state == ST_RUN) && en;

  tick_prescaler #(
    .PRESCALE(PRESCALE),
    .PS_W    (PS_W)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (w_ps_clr),
    .en  (w_ps_en),
    .tick(w_tick)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = load ? load_val : r_reload;
    w_period     = load ? load_val : r_reload;
    w_tc_nxt     = 1'b0;
    w_ps_clr     = 1'b0;

    // abort freezes the count where it is; a same-cycle load only lands in the reload register
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_ps_clr    = 1'b1;
    end else if (r_state != ST_RUN) begin
      if (start) begin
        w_ps_clr = 1'b1;
        if (w_period != '0) begin
          w_count_nxt = w_period;
          w_state_nxt = ST_RUN;
        end else begin
          w_count_nxt = '0;
          w_tc_nxt    = 1'b1;
          w_state_nxt = auto_reload ? ST_IDLE : ST_DONE;
        end
      end else if (load) begin
        w_count_nxt = load_val;
        w_state_nxt = ST_IDLE;
      end
    end else if (w_tick) begin
      if (r_count > WIDTH'(1)) begin
        w_count_nxt = r_count - 1'b1;
      end else begin
        // terminal tick reloads from the register as it stood before this edge
        w_tc_nxt = 1'b1;
        if (!auto_reload) begin
          w_count_nxt = '0;
          w_state_nxt = ST_DONE;
        end else if (r_reload == '0) begin
          w_count_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_count_nxt = r_reload;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
    end
  end

  assign count = r_count;
  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign tc    = r_tc;

endmodule

// File: tb/tb_sync_downcount_timer.sv
// tb/tb_sync_downcount_timer.sv - self-checking bench for sync_downcount_timer at PRESCALE 1 and 4
module tb_sync_downcount_timer;

  logic       clk;
  logic       rst, load, start, abort, en, auto_reload;
  logic [7:0] load_val;
  logic [7:0] count1, count4;
  logic       busy1, tc1, done1, busy4, tc4, done4;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_on = 0;

  sync_downcount_timer #(.WIDTH(8), .PRESCALE(1), .PS_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .abort(abort), .en(en), .auto_reload(auto_reload),
    .count(count1), .busy(busy1), .tc(tc1), .done(done1)
  );

  sync_downcount_timer #(.WIDTH(8), .PRESCALE(4), .PS_W(3)) u_dut4 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .abort(abort), .en(en), .auto_reload(auto_reload),
    .count(count4), .busy(busy4), .tc(tc4), .done(done4)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: mode 0=idle 1=running 2=finished; en_acc counts enabled cycles in the current tick window
  int m_mode[2], m_count[2], m_reload[2], m_tc[2], m_en_acc[2];
  int m_div[2] = '{1, 4};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_mode[k] = 0; m_count[k] = 0; m_reload[k] = 0; m_tc[k] = 0; m_en_acc[k] = 0;
      end else begin
        int old_reload, period;
        old_reload = m_reload[k];
        period     = load ? int'(load_val) : old_reload;
        m_tc[k]    = 0;
        if (abort) begin
          m_mode[k] = 0; m_en_acc[k] = 0;
        end else if (m_mode[k] != 1) begin
          if (start) begin
            m_en_acc[k] = 0;
            if (period != 0) begin
              m_count[k] = period; m_mode[k] = 1;
            end else begin
              m_count[k] = 0; m_tc[k] = 1; m_mode[k] = auto_reload ? 0 : 2;
            end
          end else if (load) begin
            m_count[k] = load_val; m_mode[k] = 0;
          end
        end else if (en) begin
          m_en_acc[k] = m_en_acc[k] + 1;
          if (m_en_acc[k] == m_div[k]) begin
            m_en_acc[k] = 0;
            if (m_count[k] > 1) m_count[k] = m_count[k] - 1;
            else begin
              m_tc[k] = 1;
              if (!auto_reload)        begin m_count[k] = 0; m_mode[k] = 2; end
              else if (old_reload == 0) begin m_count[k] = 0; m_mode[k] = 0; end
              else                      m_count[k] = old_reload;
            end
          end
        end
        if (load) m_reload[k] = load_val;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model count p1", count1, m_count[0]);
      chk("model busy p1",  busy1,  m_mode[0] == 1);
      chk("model done p1",  done1,  m_mode[0] == 2);
      chk("model tc p1",    tc1,    m_tc[0]);
      chk("model count p4", count4, m_count[1]);
      chk("model busy p4",  busy4,  m_mode[1] == 1);
      chk("model done p4",  done4,  m_mode[1] == 2);
      chk("model tc p4",    tc4,    m_tc[1]);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic quiet();
    rst = 0; load = 0; start = 0; abort = 0;
  endtask

  initial begin
    rst = 1; load = 0; start = 0; abort = 0; en = 1; auto_reload = 0; load_val = 0;
    step(); step();
    cmp_on = 1;
    chk("reset count", count1, 0);
    chk("reset busy", busy1, 0);
    chk("reset tc", tc1, 0);
    chk("reset done", done1, 0);
    quiet();
    step();

    // one-shot P=3 with load+start in the same cycle
    load = 1; load_val = 8'd3; start = 1;
    step(); quiet();
    chk("oneshot n+1 count", count1, 3);
    chk("oneshot n+1 busy", busy1, 1);
    step(); chk("oneshot n+2 count", count1, 2);
    step(); chk("oneshot n+3 count", count1, 1);
    step();
    chk("oneshot n+4 count", count1, 0);
    chk("oneshot n+4 tc", tc1, 1);
    chk("oneshot n+4 done", done1, 1);
    chk("oneshot n+4 busy", busy1, 0);
    step();
    chk("oneshot tc single", tc1, 0);
    chk("oneshot done held", done1, 1);

    // restart from reload register, second start while running is ignored
    start = 1; step();
    chk("restart count", count1, 3);
    step(); chk("start in run ignored", count1, 2);
    quiet(); step(); step();

    // reset mid-run
    load = 1; load_val = 8'd6; start = 1; step(); quiet();
    step();
    chk("pre-reset count", count1, 5);
    chk("pre-reset busy", busy1, 1);
    rst = 1; step(); rst = 0;
    chk("mid reset count", count1, 0);
    chk("mid reset busy", busy1, 0);
    chk("mid reset done", done1, 0);
    chk("mid reset tc", tc1, 0);
    step(); step();
    chk("no restart without start", busy1, 0);

    // abort with same-cycle start
    load = 1; load_val = 8'd9; start = 1; step(); quiet();
    step(); step();
    chk("pre-abort count", count1, 7);
    abort = 1; start = 1; step(); quiet();
    chk("abort count held", count1, 7);
    chk("abort busy", busy1, 0);
    chk("abort tc", tc1, 0);
    chk("abort done", done1, 0);

    // zero period start
    load = 1; load_val = 8'd0; step(); quiet();
    start = 1; step(); quiet();
    chk("zero period tc", tc1, 1);
    chk("zero period done", done1, 1);
    chk("zero period count", count1, 0);
    chk("zero period busy", busy1, 0);
    step();

    // auto-reload period 2, then reload value changed mid-run
    auto_reload = 1; load = 1; load_val = 8'd2; start = 1; step(); quiet();
    chk("ar count a", count1, 2);
    step(); chk("ar count b", count1, 1);
    step();
    chk("ar reload count", count1, 2);
    chk("ar reload tc", tc1, 1);
    chk("ar reload busy", busy1, 1);
    load = 1; load_val = 8'd4; step(); quiet();
    chk("ar after load count", count1, 1);
    step();
    chk("ar new period count", count1, 4);
    chk("ar new period tc", tc1, 1);
    step(); chk("ar new period next", count1, 3);
    abort = 1; step(); quiet();
    auto_reload = 0;
    step();

    // PRESCALE=4, period 2, en dropped for three cycles mid-count
    load = 1; load_val = 8'd2; start = 1; en = 1; step(); quiet();
    chk("ps4 start count", count4, 2);
    step(); step();
    en = 0; step(); step(); step();
    chk("ps4 frozen count", count4, 2);
    en = 1; step(); step();
    chk("ps4 first decrement", count4, 1);
    step(); step(); step();
    chk("ps4 before tc", count4, 1);
    step();
    chk("ps4 tc count", count4, 0);
    chk("ps4 tc", tc4, 1);
    chk("ps4 done", done4, 1);
    step();

    // randomized traffic checked against the model every cycle
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst   = ($urandom_range(0, 149) == 0);
      load  = ($urandom_range(0, 7) == 0);
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 39) == 0);
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) auto_reload = ~auto_reload;
      r = $urandom_range(0, 9);
      load_val = (r == 9) ? 8'($urandom_range(0, 255)) : 8'(r);
      step();
    end
    quiet();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
